// File: rtl/shift_register_pkg.sv
// Shared types for the shift register: the operation-select encoding.
package shift_register_pkg;

  typedef enum logic [1:0] {
    HOLD        = 2'd0,
    SHIFT_LEFT  = 2'd1,
    SHIFT_RIGHT = 2'd2,
    LOAD        = 2'd3
  } ctrl_e;

endpackage

// File: rtl/shift_register_if.sv
// Operation/data bundle for the shift register.
// The master drives the operation; the slave (the register) returns its state.
interface shift_register_if
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8
);
  ctrl_e             ctrl;
  logic              ser_in;
  logic [WIDTH-1:0]  par_in;
  logic [WIDTH-1:0]  par_out;
  logic              ser_out;

  modport master (output ctrl, output ser_in, output par_in,
                  input  par_out, input ser_out);
  modport slave  (input  ctrl, input  ser_in, input  par_in,
                  output par_out, output ser_out);
endinterface

// File: rtl/shift_register.sv
// WIDTH-bit bidirectional shift register with parallel load.
// Both outputs come straight from flops; there is no other state.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  shift_register_if.slave bus
);

  logic [WIDTH-1:0] par_q;
  logic             ser_q;

  // Single clocked process: reset wins over every operation, then decode ctrl.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= '0;
      ser_q <= 1'b0;
    end else begin
      case (bus.ctrl)
        SHIFT_LEFT: begin
          par_q <= {par_q[WIDTH-2:0], bus.ser_in};
          ser_q <= par_q[WIDTH-1];
        end
        SHIFT_RIGHT: begin
          par_q <= {bus.ser_in, par_q[WIDTH-1:1]};
          ser_q <= par_q[0];
        end
        LOAD: begin
          par_q <= bus.par_in;   // ser_q deliberately keeps its value
        end
        default: begin           // HOLD
          par_q <= par_q;
          ser_q <= ser_q;
        end
      endcase
    end
  end

  assign bus.par_out = par_q;
  assign bus.ser_out = ser_q;

endmodule

// File: tb/tb_shift_register.sv
// Directed bench: driver applies hand-computed vectors and queues the
// expected post-edge state; a monitor pops and compares after each edge.
module tb_shift_register;
  import shift_register_pkg::*;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  shift_register_if #(.WIDTH(WIDTH)) bus();

  shift_register #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    ctrl_e       ctrl;
    logic        ser_in;
    logic [7:0]  par_in;
    logic [7:0]  exp_par;
    logic        exp_ser;
  } vec_t;

  typedef struct {
    int          idx;
    logic [7:0]  exp_par;
    logic        exp_ser;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[19];

  initial begin
    // reset beats LOAD 0xFF
    vecs[0]  = '{1'b1, LOAD,        1'b0, 8'hFF, 8'h00, 1'b0};
    // right shifts 1,0,1,1,0 from 0x00
    vecs[1]  = '{1'b0, SHIFT_RIGHT, 1'b1, 8'h5A, 8'h80, 1'b0};
    vecs[2]  = '{1'b0, SHIFT_RIGHT, 1'b0, 8'h5A, 8'h40, 1'b0};
    vecs[3]  = '{1'b0, SHIFT_RIGHT, 1'b1, 8'h5A, 8'hA0, 1'b0};
    vecs[4]  = '{1'b0, SHIFT_RIGHT, 1'b1, 8'h5A, 8'hD0, 1'b0};
    vecs[5]  = '{1'b0, SHIFT_RIGHT, 1'b0, 8'h5A, 8'h68, 1'b0};
    // load 152, ser_in ignored
    vecs[6]  = '{1'b0, LOAD,        1'b1, 8'd152, 8'h98, 1'b0};
    // left shifts 1,1,0
    vecs[7]  = '{1'b0, SHIFT_LEFT,  1'b1, 8'h00, 8'h31, 1'b1};
    vecs[8]  = '{1'b0, SHIFT_LEFT,  1'b1, 8'h00, 8'h63, 1'b0};
    vecs[9]  = '{1'b0, SHIFT_LEFT,  1'b0, 8'h00, 8'hC6, 1'b0};
    // hold twice with noisy inputs
    vecs[10] = '{1'b0, HOLD,        1'b1, 8'hFF, 8'hC6, 1'b0};
    vecs[11] = '{1'b0, HOLD,        1'b1, 8'hFF, 8'hC6, 1'b0};
    // right shift in 0, then 1 (bit0 of 0x63 goes out)
    vecs[12] = '{1'b0, SHIFT_RIGHT, 1'b0, 8'hFF, 8'h63, 1'b0};
    vecs[13] = '{1'b0, SHIFT_RIGHT, 1'b1, 8'hFF, 8'hB1, 1'b1};
    // mid-sequence reset, then shifting resumes from zero
    vecs[14] = '{1'b1, SHIFT_RIGHT, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[15] = '{1'b0, SHIFT_RIGHT, 1'b1, 8'h00, 8'h80, 1'b0};
    vecs[16] = '{1'b0, SHIFT_LEFT,  1'b1, 8'h00, 8'h01, 1'b1};
    // load keeps ser_out high
    vecs[17] = '{1'b0, LOAD,        1'b0, 8'hA5, 8'hA5, 1'b1};
    // reset against LOAD 0xFF from a nonzero state
    vecs[18] = '{1'b1, LOAD,        1'b1, 8'hFF, 8'h00, 1'b0};
  end

  // Driver: apply each vector on the falling edge and queue its expectation.
  initial begin
    exp_t e;
    int   wait_cyc;
    rst        = 1'b0;
    bus.ctrl   = HOLD;
    bus.ser_in = 1'b0;
    bus.par_in = '0;
    #1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      bus.ctrl   = vecs[i].ctrl;
      bus.ser_in = vecs[i].ser_in;
      bus.par_in = vecs[i].par_in;
      e.idx     = i;
      e.exp_par = vecs[i].exp_par;
      e.exp_ser = vecs[i].exp_ser;
      exp_q.push_back(e);
      // Reset raised between edges must not disturb the outputs yet.
      if (vecs[i].rst && i > 0) begin
        #2;
        checks++;
        if (bus.par_out !== vecs[i-1].exp_par || bus.ser_out !== vecs[i-1].exp_ser) begin
          errors++;
          $display("FAIL sync_rst vec%0d: par_out=%h ser_out=%b, required par_out=%h ser_out=%b",
                   i, bus.par_out, bus.ser_out, vecs[i-1].exp_par, vecs[i-1].exp_ser);
        end
      end
    end
    @(negedge clk);
    rst      = 1'b0;
    bus.ctrl = HOLD;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Monitor: one result per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.par_out !== e.exp_par) begin
          errors++;
          $display("FAIL par_out vec%0d: got %h, required %h", e.idx, bus.par_out, e.exp_par);
        end
        checks++;
        if (bus.ser_out !== e.exp_ser) begin
          errors++;
          $display("FAIL ser_out vec%0d: got %b, required %b", e.idx, bus.ser_out, e.exp_ser);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
